alu_seq: RTL and testbench
==========================

# alu_seq

Multi-cycle sequencer for the RV32I integer ALU datapath. Accepts one operation at a time over a valid/ready request channel and computes non-shift functions in a single execute cycle through the combinational function units. It performs SLL/SRL/SRA serially, one bit per cycle. The registered result is returned on a valid/ready response channel; the block sits between decode/issue and writeback.

## Interface
- `XLEN`, 32, datapath width. Only 32 is supported.
- `clk`, input, 1, single clock; all state updates on the rising edge.
- `rst_n`, input, 1, reset, synchronous and active-low.
- `req_valid`, input, 1, request present.
- `req_ready`, output, 1, block can accept a request.
- `req_op`, input, 4, operation {funct7[5], funct3}.
- `req_a`, input, XLEN, operand A (rs1).
- `req_b`, input, XLEN, operand B (rs2/imm).
- `rsp_valid`, output, 1, result valid.
- `rsp_ready`, input, 1, consumer takes the result.
- `rsp_y`, output, XLEN, result.
- `busy`, output, 1, high in any state other than IDLE.

## Operation
- Opcodes:
  - ADD 0000, SUB 1000, SLT 0010, SLTU 0011, XOR 0100, OR 0110, AND 0111.
  - SLL 0001, SRL 0101, SRA 1101.
  - Any other code produces result 0 and takes the non-shift path.
- FSM states: IDLE, EXEC, SHIFT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch `a`, `b` and `op`.
  - Shift ops go to SHIFT, loading `sreg`=`req_a` and `cnt`=`req_b[4:0]`.
  - All other ops go to EXEC.
- EXEC: `rsp_y`<=comb result of latched operands, then go to RESP.
- SHIFT:
  - If `cnt`!=0: shift `sreg` by 1 and `cnt`--. SLL fills 0 at LSB, SRL fills 0 at MSB, SRA replicates `sreg[31]`.
  - If `cnt`==0: `rsp_y`<=`sreg`, then go to RESP.
- RESP:
  - `rsp_valid`=1; `rsp_y` is held stable.
  - On `rsp_ready`, go to IDLE.
  - `req_ready`=0 in this state; there is no same-cycle re-accept.
- Arithmetic:
  - ADD/SUB wrap mod 2^32.
  - SLT compares signed, SLTU unsigned; both return 32'h0000_0001 or 0.
  - Shift amount uses only `b[4:0]`; `b[31:5]` is ignored.
- Request inputs are ignored whenever `req_ready`=0.
- `rsp_ready` is ignored outside RESP.

## Timing
- Reset (`rst_n` low at an edge):
  - State goes to IDLE; `rsp_valid`=0, `rsp_y`=0, `cnt`=0, `sreg`=0.
  - `req_ready` is 0 while `rst_n` is low and 1 in the first cycle after release.
- Reset mid-operation (EXEC/SHIFT/RESP) aborts immediately. The in-flight result is discarded and never presented.
- Latency, counted from the accept edge to `rsp_valid` high:
  - Non-shift: 1 cycle (accept edge, EXEC edge, then valid).
  - Shift: 1+shamt cycles; shamt=0 equals the non-shift latency, shamt=31 gives 32 cycles.
- Minimum request-to-request spacing is 3 cycles (IDLE, EXEC, RESP with `rsp_ready`=1).
- Response backpressure: `rsp_valid`/`rsp_y` hold for any number of cycles until `rsp_ready`.
- `busy` = (state!=IDLE); it is registered-state derived, with no combinational path from inputs.
- `req_ready`, `rsp_valid` and `busy` are functions of state (and `rst_n` for `req_ready`) only, with no combinational input-to-output paths.

## Structure
- Shared package `alu_pkg`:
  - Opcode localparams (OP_ADD … OP_SRA).
  - FSM state encoding (2 bits).
  - `XLEN` default.
- Sub-module `alu_comb`:
  - Purely combinational; (op, a, b) -> y for all non-shift ops.
  - Wraps the existing per-function units (and/or/xor/add/sub/slt/sltu).
- Serial shifter (`sreg`, `cnt`) and FSM live in `alu_seq` itself.

## Test plan
- Reset then OR: a=32'h0000_FFFF, b=32'hFFFF_0000 -> `rsp_valid` 1 cycle after accept, `rsp_y`=32'hFFFF_FFFF. `req_ready`=0 until the response handshake.
- SUB wrap and SLT/SLTU:
  - SUB 0-1 -> 32'hFFFF_FFFF.
  - SLT a=32'hFFFF_FFFF, b=1 -> 1.
  - SLTU with the same operands -> 0.
- Shifts:
  - SRA a=32'h8000_0000, b=31 -> 32'hFFFF_FFFF after 32 cycles.
  - SRL with the same operands -> 32'h0000_0001.
  - SLL a=1, b=32'hFFFF_FFE0 (shamt 0) -> 1 after 1 cycle.
- Backpressure: hold `rsp_ready`=0 for 10 cycles after AND a=32'hF0F0_F0F0, b=32'hFF00_FF00 -> `rsp_y`=32'hF000_F000 stable throughout, `req_valid` pulses ignored, `busy`=1.
- Reset mid-shift: SLL shamt=20, assert `rst_n`=0 at cycle 5 -> next cycle `rsp_valid`=0, `rsp_y`=0, `busy`=0. The result never appears.
- Undefined op 1111 with a=b=32'hFFFF_FFFF -> `rsp_y`=0 with non-shift latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the RV32I ALU sequencer: opcodes, FSM encoding, width default.
package alu_pkg;

   localparam int unsigned XLEN_DEFAULT = 32;

   localparam logic [3:0] OP_ADD  = 4'b0000;
   localparam logic [3:0] OP_SLL  = 4'b0001;
   localparam logic [3:0] OP_SLT  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_XOR  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_OR   = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;
   localparam logic [3:0] OP_SUB  = 4'b1000;
   localparam logic [3:0] OP_SRA  = 4'b1101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EXEC  = 2'd1,
      S_SHIFT = 2'd2,
      S_RESP  = 2'd3
   } state_e;

   function automatic logic is_shift(input logic [3:0] op);
      return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
   endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational non-shift ALU functions; unknown and shift codes yield zero.
module alu_comb
   import alu_pkg::*;
#(
   parameter int unsigned W = XLEN_DEFAULT
) (
   input  logic [3:0]   op_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   output logic [W-1:0] y_o
);

   logic [W-1:0] and_y;
   logic [W-1:0] or_y;
   logic [W-1:0] xor_y;
   logic [W-1:0] add_y;
   logic [W-1:0] sub_y;
   logic [W-1:0] slt_y;
   logic [W-1:0] sltu_y;

   assign and_y  = a_i & b_i;
   assign or_y   = a_i | b_i;
   assign xor_y  = a_i ^ b_i;
   assign add_y  = a_i + b_i;
   assign sub_y  = a_i - b_i;
   assign slt_y  = {{(W-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
   assign sltu_y = {{(W-1){1'b0}}, (a_i < b_i)};

   always_comb begin
      y_o = '0;
      case (op_i)
         OP_ADD:  y_o = add_y;
         OP_SUB:  y_o = sub_y;
         OP_SLT:  y_o = slt_y;
         OP_SLTU: y_o = sltu_y;
         OP_XOR:  y_o = xor_y;
         OP_OR:   y_o = or_y;
         OP_AND:  y_o = and_y;
         default: y_o = '0;
      endcase
   end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU sequencer: single-cycle non-shift ops, bit-serial shifts,
// registered result on a valid/ready response channel.
module alu_seq
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = XLEN_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_y,
   output logic            busy
);

   state_e          state_q, state_d;
   logic [3:0]      op_q, op_d;
   logic [XLEN-1:0] a_q, a_d;
   logic [XLEN-1:0] b_q, b_d;
   logic [XLEN-1:0] sreg_q, sreg_d;
   logic [4:0]      cnt_q, cnt_d;
   logic [XLEN-1:0] y_q, y_d;
   logic [XLEN-1:0] comb_y;

   alu_comb #(.W(XLEN)) u_comb (
      .op_i (op_q),
      .a_i  (a_q),
      .b_i  (b_q),
      .y_o  (comb_y)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sreg_q  <= '0;
         cnt_q   <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         y_q     <= y_d;
      end
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      a_d     = a_q;
      b_d     = b_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      y_d     = y_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               op_d = req_op;
               a_d  = req_a;
               b_d  = req_b;
               if (is_shift(req_op)) begin
                  sreg_d  = req_a;
                  cnt_d   = req_b[4:0];
                  state_d = S_SHIFT;
               end else begin
                  state_d = S_EXEC;
               end
            end
         end
         S_EXEC: begin
            y_d     = comb_y;
            state_d = S_RESP;
         end
         S_SHIFT: begin
            if (cnt_q != 5'd0) begin
               cnt_d = cnt_q - 5'd1;
               case (op_q)
                  OP_SLL:  sreg_d = {sreg_q[XLEN-2:0], 1'b0};
                  OP_SRA:  sreg_d = {sreg_q[XLEN-1], sreg_q[XLEN-1:1]};
                  default: sreg_d = {1'b0, sreg_q[XLEN-1:1]};
               endcase
            end else begin
               y_d     = sreg_q;
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            if (rsp_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // req_ready also depends on rst_n so nothing is accepted while reset is held
   always_comb begin
      req_ready = (state_q == S_IDLE) && rst_n;
      rsp_valid = (state_q == S_RESP);
      busy      = (state_q != S_IDLE);
      rsp_y     = y_q;
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with an expected-result scoreboard queue.
module tb_alu_seq;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_y;
   logic        busy;

   int unsigned checks;
   int unsigned passes;
   int unsigned fails;
   logic [31:0] exp_q[$];

   alu_seq #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_y     (rsp_y),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request, measure latency, optionally stall the response while
   // poking req_valid, then complete the handshake and compare against the queue.
   task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_y,
                         input int unsigned exp_lat, input int unsigned hold);
      int unsigned lat;
      logic [31:0] e;
      logic        stable;
      chk({tag, "_ready_before"}, {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      exp_q.push_back(exp_y);
      tick();
      req_valid = 1'b0;
      req_a     = ~a;
      req_b     = ~b;
      lat = 0;
      while (!rsp_valid && lat < 100) begin
         chk({tag, "_ready_wait"}, {31'd0, req_ready}, 32'd0);
         tick();
         lat++;
      end
      chk({tag, "_latency"}, lat, exp_lat);
      chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
      e = exp_q.pop_front();
      chk({tag, "_y"}, rsp_y, e);
      stable = 1'b1;
      for (int i = 0; i < int'(hold); i++) begin
         req_valid = (i % 2) == 0;
         req_op    = 4'b0000;
         req_a     = 32'h1234_5678 + i;
         req_b     = 32'h1111_1111;
         tick();
         if (rsp_y !== e || rsp_valid !== 1'b1 || busy !== 1'b1 || req_ready !== 1'b0)
            stable = 1'b0;
      end
      req_valid = 1'b0;
      if (hold != 0) chk({tag, "_held_stable"}, {31'd0, stable}, 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      chk({tag, "_valid_after"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      logic seen;
      checks = 0; passes = 0; fails = 0;
      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
      tick();
      tick();
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_y", rsp_y, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready_low", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b1;
      tick();
      chk("rst_ready_high", {31'd0, req_ready}, 32'd1);

      run_op("or",   4'b0110, 32'h0000_FFFF, 32'hFFFF_0000, 32'hFFFF_FFFF, 1, 0);
      run_op("sub",  4'b1000, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1, 0);
      run_op("slt",  4'b0010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1, 0);
      run_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1, 0);
      run_op("add",  4'b0000, 32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, 1, 0);
      run_op("xor",  4'b0100, 32'hA5A5_0F0F, 32'hFFFF_0000, 32'h5A5A_0F0F, 1, 0);
      run_op("sra",  4'b1101, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 32, 0);
      run_op("srl",  4'b0101, 32'h8000_0000, 32'd31, 32'h0000_0001, 32, 0);
      run_op("sll0", 4'b0001, 32'h0000_0001, 32'hFFFF_FFE0, 32'h0000_0001, 1, 0);
      run_op("sll4", 4'b0001, 32'h0000_00F1, 32'h0000_0024, 32'h0000_0F10, 5, 0);
      run_op("and_bp", 4'b0111, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1, 10);
      run_op("undef", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0);

      // Reset in the middle of a 20-bit SLL; the result must never surface.
      req_valid = 1'b1; req_op = 4'b0001; req_a = 32'h0000_0001; req_b = 32'd20;
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("mid_busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      tick();
      chk("mid_valid", {31'd0, rsp_valid}, 32'd0);
      chk("mid_y", rsp_y, 32'd0);
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_ready_low", {31'd0, req_ready}, 32'd0);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      tick();
      chk("mid_ready_high", {31'd0, req_ready}, 32'd1);
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (rsp_valid || busy) seen = 1'b1;
      end
      rsp_ready = 1'b0;
      chk("mid_never_presented", {31'd0, seen}, 32'd0);

      run_op("post_add", 4'b0000, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030, 1, 0);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
